// File: rtl/mips_stage_writeback_pkg.sv
// Shared types and constants for the MIPS writeback stage.
//
// Contents:
//   - Bit positions of the fields in the packed MemReg control word.
//   - Load size encoding (byte / half / word).
//   - Link offset (return address = pc + 8).
//   - Register index type and the special register indices (zero, ra).
package mips_stage_writeback_pkg;

    // Packed control word carried by the MemReg bundle.
    localparam int unsigned CTRL_W            = 8;
    localparam int unsigned CTRL_VALID        = 0;
    localparam int unsigned CTRL_REG_WRITE    = 1;
    localparam int unsigned CTRL_MEM_TO_REG   = 2;
    localparam int unsigned CTRL_REG_DST      = 3;
    localparam int unsigned CTRL_LINK         = 4;
    localparam int unsigned CTRL_LOAD_SIGNED  = 5;
    localparam int unsigned CTRL_LOAD_SIZE_LO = 6;  // two bits: [7:6]

    typedef enum logic [1:0] {
        LoadByte = 2'd0,
        LoadHalf = 2'd1,
        LoadWord = 2'd2
    } load_size_e;

    // jal/jalr write the address of the instruction after the delay slot.
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef logic [4:0] reg_idx_t;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/mips_stage_writeback_regfile.sv
// Architectural register file: one write port, two combinational read ports.
//
// Parameters:
//   INVERT_CTRL  1: write on the falling edge so a same-cycle read sees the new value.
//                0: write on the rising edge; a matching read is bypassed from the write port.
//   REG_L        number of registers; REG_W index width.
//   RESET_CLEAR  1: synchronous reset clears every register. 0: contents survive reset.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset (blocks any write)
//   i_we, i_waddr, i_wdata  write port; i_we must already exclude register 0
//   i_raddr1/2, o_rdata1/2  read ports; register 0 always reads 0
module mips_stage_writeback_regfile #(
    parameter int unsigned INVERT_CTRL = 1,
    parameter int unsigned REG_L       = 32,
    parameter int unsigned REG_W       = $clog2(REG_L),
    parameter int unsigned RESET_CLEAR = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [REG_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic [REG_W-1:0] i_raddr1,
    input  logic [REG_W-1:0] i_raddr2,
    output logic [31:0]      o_rdata1,
    output logic [31:0]      o_rdata2
);

    logic [31:0] w_regs [REG_L];

    for (genvar g = 0; g < REG_L; g++) begin : g_reg
        if (g == 0) begin : g_zero
            // Register 0 has no storage at all.
            assign w_regs[g] = '0;
        end else begin : g_store
            logic [31:0] r_q;
            logic        w_hit;

            assign w_hit = i_we & (i_waddr == REG_W'(g));

            if (INVERT_CTRL != 0) begin : g_neg
                always_ff @(negedge i_clk) begin
                    if (i_reset) begin
                        if (RESET_CLEAR != 0) begin
                            r_q <= '0;
                        end
                    end else if (w_hit) begin
                        r_q <= i_wdata;
                    end
                end
            end else begin : g_pos
                always_ff @(posedge i_clk) begin
                    if (i_reset) begin
                        if (RESET_CLEAR != 0) begin
                            r_q <= '0;
                        end
                    end else if (w_hit) begin
                        r_q <= i_wdata;
                    end
                end
            end

            assign w_regs[g] = r_q;
        end
    end

    always_comb begin
        o_rdata1 = w_regs[i_raddr1];
        o_rdata2 = w_regs[i_raddr2];
        // Rising-edge storage lags the decode read by a cycle; forward the pending write.
        if (INVERT_CTRL == 0) begin
            if (i_we && (i_raddr1 == i_waddr)) begin
                o_rdata1 = i_wdata;
            end
            if (i_we && (i_raddr2 == i_waddr)) begin
                o_rdata2 = i_wdata;
            end
        end
    end

endmodule

// File: rtl/mips_stage_writeback.sv
// MIPS writeback stage: consumer end of the MemReg pipeline bundle.
// Unpacks the bundle, aligns/extends load data, selects the writeback value,
// owns the register file and exports forwarding and retire information.
//
// Optional feature macro: MIPS_STAGE_WRITEBACK_RETIRE_COUNT_EN
//   defined   -> adds o_retire_count (retired instruction counter) and o_last_pc.
//   undefined -> neither port nor any counter logic exists.
//
// Ports:
//   i_clk, i_reset                         clock, synchronous active-high reset
//   i_instruction, i_pc_addr, i_mem_out,
//   i_alu_result, i_control                MemReg bundle (control word layout in package)
//   i_read_addr1/2, o_read_data1/2         decode read ports (combinational)
//   o_fwd_valid, o_fwd_addr, o_fwd_data    registered copy of the write just performed
//   o_retire                               one-cycle pulse per valid instruction
module mips_stage_writeback
    import mips_stage_writeback_pkg::*;
#(
    parameter int unsigned INVERT_CTRL = 1,
    parameter int unsigned REG_L       = 32,
    parameter int unsigned REG_W       = $clog2(REG_L),
    parameter int unsigned RESET_CLEAR = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [31:0]       i_instruction,
    input  logic [31:0]       i_pc_addr,
    input  logic [31:0]       i_mem_out,
    input  logic [31:0]       i_alu_result,
    input  logic [CTRL_W-1:0] i_control,
    input  logic [REG_W-1:0]  i_read_addr1,
    input  logic [REG_W-1:0]  i_read_addr2,
    output logic [31:0]       o_read_data1,
    output logic [31:0]       o_read_data2,
    output logic              o_fwd_valid,
    output logic [REG_W-1:0]  o_fwd_addr,
    output logic [31:0]       o_fwd_data,
    output logic              o_retire
`ifdef MIPS_STAGE_WRITEBACK_RETIRE_COUNT_EN
    ,
    output logic [31:0]       o_retire_count,
    output logic [31:0]       o_last_pc
`endif
);

    logic             w_valid;
    logic             w_reg_write;
    logic             w_mem_to_reg;
    logic             w_reg_dst;
    logic             w_link;
    logic             w_load_signed;
    load_size_e       w_load_size;
    logic [1:0]       w_offset;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_value;
    logic [REG_W-1:0] w_dest;
    logic             w_we;
    logic             w_unused;

    logic             r_fwd_valid;
    logic [REG_W-1:0] r_fwd_addr;
    logic [31:0]      r_fwd_data;
    logic             r_retire;

    // Only the rt/rd fields of the instruction matter here.
    assign w_unused = ^{i_instruction[31:21], i_instruction[10:0]};

    assign w_valid       = i_control[CTRL_VALID];
    assign w_reg_write   = i_control[CTRL_REG_WRITE];
    assign w_mem_to_reg  = i_control[CTRL_MEM_TO_REG];
    assign w_reg_dst     = i_control[CTRL_REG_DST];
    assign w_link        = i_control[CTRL_LINK];
    assign w_load_signed = i_control[CTRL_LOAD_SIGNED];
    assign w_load_size   = load_size_e'(i_control[CTRL_LOAD_SIZE_LO +: 2]);
    assign w_offset      = i_alu_result[1:0];

    always_comb begin
        w_dest = REG_W'(i_instruction[20:16]);
        if (w_link) begin
            w_dest = REG_W'(REG_RA);
        end else if (w_reg_dst) begin
            w_dest = REG_W'(i_instruction[15:11]);
        end
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        unique case (w_offset)
            2'd0: w_byte = i_mem_out[31:24];
            2'd1: w_byte = i_mem_out[23:16];
            2'd2: w_byte = i_mem_out[15:8];
            2'd3: w_byte = i_mem_out[7:0];
        endcase
        // offset[0] is ignored for halfwords; misalignment is trapped upstream.
        w_half = w_offset[1] ? i_mem_out[15:0] : i_mem_out[31:16];

        w_load = i_mem_out;
        case (w_load_size)
            LoadByte: w_load = {{24{w_load_signed & w_byte[7]}}, w_byte};
            LoadHalf: w_load = {{16{w_load_signed & w_half[15]}}, w_half};
            default:  w_load = i_mem_out;
        endcase
    end

    always_comb begin
        w_value = i_alu_result;
        if (w_link) begin
            w_value = i_pc_addr + LINK_OFFSET;
        end else if (w_mem_to_reg) begin
            w_value = w_load;
        end
    end

    // Reset suppresses the write of whatever instruction is in the stage.
    assign w_we = w_valid & w_reg_write & (w_dest != REG_W'(REG_ZERO)) & ~i_reset;

    mips_stage_writeback_regfile #(
        .INVERT_CTRL (INVERT_CTRL),
        .REG_L       (REG_L),
        .REG_W       (REG_W),
        .RESET_CLEAR (RESET_CLEAR)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (w_we),
        .i_waddr  (w_dest),
        .i_wdata  (w_value),
        .i_raddr1 (i_read_addr1),
        .i_raddr2 (i_read_addr2),
        .o_rdata1 (o_read_data1),
        .o_rdata2 (o_read_data2)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_retire    <= 1'b0;
        end else begin
            r_fwd_valid <= w_we;
            // Address/data keep the last real write while no write is in flight.
            if (w_we) begin
                r_fwd_addr <= w_dest;
                r_fwd_data <= w_value;
            end
            r_retire <= w_valid;
        end
    end

    assign o_fwd_valid = r_fwd_valid;
    assign o_fwd_addr  = r_fwd_addr;
    assign o_fwd_data  = r_fwd_data;
    assign o_retire    = r_retire;

`ifdef MIPS_STAGE_WRITEBACK_RETIRE_COUNT_EN
    logic [31:0] r_retire_count;
    logic [31:0] r_last_pc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_retire_count <= '0;
            r_last_pc      <= '0;
        end else if (w_valid) begin
            r_retire_count <= r_retire_count + 32'd1;
            r_last_pc      <= i_pc_addr;
        end
    end

    assign o_retire_count = r_retire_count;
    assign o_last_pc      = r_last_pc;
`endif

endmodule

// File: doc/mips_stage_writeback.md
Name: mips_stage_writeback

Overview:
Consumer end of the MemReg pipeline interface; the final pipeline stage.
- Unpacks the MemReg bundle, aligns and extends load data, and selects the writeback value.
- Owns the 32x32 architectural register file: one write port, two read ports for the decode stage.
- Exports a forwarding bundle and a retire strobe to the hazard unit.

Parameters:
INVERT_CTRL, 1, 1: register file writes on falling clock edge (decode reads written value same cycle); 0: rising edge plus internal write-through bypass
REG_L, 32, number of architectural registers
REG_W, Util_Math_log2(REG_L), register index width
RESET_CLEAR, 1, 1: all registers cleared to 0 on reset; 0: only valid/retire state reset

Ports:
ctrl  input  Data_Control_Control_T  ctrl.clock plus ctrl.reset; reset is synchronous, active-high
pipeMemReg  input  Mips_Pipeline_MemReg_T  instruction, pcAddr, memOut, aluResult, control
readAddr1  input  REG_W  decode read port 1 index
readAddr2  input  REG_W  decode read port 2 index
readData1  output  32  read port 1 data, combinational
readData2  output  32  read port 2 data, combinational
fwdValid  output  1  registered: a register write is in flight this cycle
fwdAddr  output  REG_W  destination of in-flight write
fwdData  output  32  value of in-flight write
retire  output  1  one-cycle pulse per valid instruction leaving the pipe

Behaviour:
- Stage valid = control.valid from the MemReg bundle; bubbles have valid=0 and cause no side effects.
- Destination index:
  - control.link=1: 31
  - else control.regDst=1: instruction[15:11]
  - else: instruction[20:16]
- Load extraction, when control.memToReg=1; byte offset = aluResult[1:0], big-endian lanes:
  - loadSize=BYTE: lane (3-offset)*8, sign- or zero-extended per control.loadSigned
  - loadSize=HALF: lane selected by offset[1], extended likewise; offset[0]=1 is ignored (address fault is an upstream concern)
  - loadSize=WORD: memOut unchanged
- Writeback value select:
  - link=1: pcAddr+8, 32-bit wrap
  - else memToReg=1: extracted load
  - else: aluResult
- Write enable = valid & control.regWrite & (dest != 0). Register 0 is never written and always reads 0.
- Write timing:
  - INVERT_CTRL=1: write on negedge ctrl.clock.
  - INVERT_CTRL=0: write on posedge. A read whose address equals the current write dest (nonzero, write enabled) returns the write value combinationally.
- Forwarding registers (posedge), latency 1 cycle after the MemReg bundle presents the write:
  - fwdValid <= write enable; fwdAddr <= dest; fwdData <= write value.
  - fwdAddr/fwdData hold their previous values when fwdValid=0.
- retire (posedge) <= valid; always 1-cycle pulses, even back-to-back.
- Reset (synchronous, ctrl.reset=1 at posedge):
  - fwdValid=0, fwdAddr=0, fwdData=0, retire=0.
  - RESET_CLEAR=1: all registers 0.
  - Reset dominates any same-cycle write; the instruction in the stage during reset is discarded, no retire.
- Simultaneous events:
  - Reads of both ports to the same register are allowed.
  - Write to r0 with regWrite=1 retires but writes nothing; fwdValid stays 0.
- Reset deasserted mid-stream: the first valid bundle after reset writes normally.

Optional Feature:
MIPS_STAGE_WRITEBACK_RETIRE_COUNT_EN
- Defined:
  - Adds output retireCount, 32 bits: posedge counter incremented by each valid instruction, cleared by reset, wraps 0xFFFFFFFF -> 0.
  - Adds output lastPc, 32 bits: pcAddr of the last retired instruction, reset 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package Mips_Type_Control: loadSize enum (BYTE, HALF, WORD), control field accessors (valid, regWrite, memToReg, regDst, link, loadSigned), link offset constant 8.
- Package Mips_Type_Reg: register index type, REG_ZERO=0, REG_RA=31.
- Sub-module mips_datapath_regfile: storage, write edge select, bypass. The stage instantiates it and keeps unpack, extraction, select and forwarding logic.

Test Plan:
- ALU write: regWrite=1, regDst=1, rd=5, aluResult=0x12345678 -> next cycle readData1(5)=0x12345678; fwdValid=1, fwdAddr=5; retire=1.
- Signed byte load: memOut=0x11F23344, aluResult[1:0]=1, BYTE, signed, rt=7 -> r7=0xFFFFFFF2. Same case unsigned -> r7=0x000000F2.
- Half load: memOut=0x8001ABCD, offset=2, signed -> 0xFFFFABCD.
- jal: link=1, pcAddr=0x00400010 -> r31=0x00400018.
- r0 protection: write 0xDEADBEEF to r0 -> readData of r0=0, fwdValid=0, retire=1.
- Reset and bypass: reset asserted during a valid write to r3 -> r3=0, no retire. INVERT_CTRL=0: same-cycle read of r3 during write of 0xA5 -> readData=0xA5. Feature enabled: 3 valid instructions + 1 bubble -> retireCount=3.
